// File: rtl/read_d_fetch.sv
// Read/D ROM fetch stage: looks up (i, z) in the read/D ROM in the accept cycle and
// queues {i, sym, d, prune, done} in a small response FIFO with saturating statistics.
module read_d_fetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_i,
  input  logic [7:0]       req_z,
  output logic             rom_ce,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_d_i,
  input  logic [1:0]       rom_read_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_i,
  output logic [1:0]       rsp_sym,
  output logic [7:0]       rsp_d,
  output logic             rsp_prune,
  output logic             rsp_done,
  output logic [CNT_W-1:0] cnt_req,
  output logic [CNT_W-1:0] cnt_prune
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0] i_q     [DEPTH];
  logic [1:0] sym_q   [DEPTH];
  logic [7:0] d_q     [DEPTH];
  logic       prune_q [DEPTH];
  logic       done_q  [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] cnt_req_q, cnt_req_d;
  logic [CNT_W-1:0] cnt_prune_q, cnt_prune_d;

  logic       push, pop;
  logic [1:0] ent_sym;
  logic [7:0] ent_d;
  logic       ent_prune, ent_done;

  assign rsp_valid = (count_q != '0);
  // rst_n gates ready so nothing is accepted (and the ROM stays idle) while held in reset
  assign req_ready = rst_n && !flush && ((count_q < FULL) || (rsp_valid && rsp_ready));
  assign rom_ce    = req_valid && req_ready;
  assign rom_addr  = rom_ce ? req_i : '0;

  assign rsp_i     = rsp_valid ? i_q[rd_ptr_q]     : '0;
  assign rsp_sym   = rsp_valid ? sym_q[rd_ptr_q]   : '0;
  assign rsp_d     = rsp_valid ? d_q[rd_ptr_q]     : '0;
  assign rsp_prune = rsp_valid ? prune_q[rd_ptr_q] : 1'b0;
  assign rsp_done  = rsp_valid ? done_q[rd_ptr_q]  : 1'b0;

  assign cnt_req   = cnt_req_q;
  assign cnt_prune = cnt_prune_q;

  always_comb begin
    push = req_valid && req_ready;
    pop  = rsp_valid && rsp_ready && !flush;

    // With z >= 0 the 9-bit signed compare reduces to an unsigned z < d
    ent_sym   = rom_read_i;
    ent_d     = rom_d_i;
    ent_prune = req_z[7] || ({1'b0, req_z} < {1'b0, rom_d_i});
    ent_done  = 1'b0;
    if (req_i == 8'hFF) begin
      ent_sym   = '0;
      ent_d     = '0;
      ent_prune = req_z[7];
      ent_done  = !req_z[7];
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    cnt_req_d   = cnt_req_q;
    cnt_prune_d = cnt_prune_q;
    if (push && (cnt_req_q != '1))               cnt_req_d   = cnt_req_q + 1'b1;
    if (push && ent_prune && (cnt_prune_q != '1)) cnt_prune_d = cnt_prune_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_req_q   <= '0;
      cnt_prune_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        i_q[k]     <= '0;
        sym_q[k]   <= '0;
        d_q[k]     <= '0;
        prune_q[k] <= 1'b0;
        done_q[k]  <= 1'b0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_req_q   <= cnt_req_d;
      cnt_prune_q <= cnt_prune_d;
      if (push) begin
        i_q[wr_ptr_q]     <= req_i;
        sym_q[wr_ptr_q]   <= ent_sym;
        d_q[wr_ptr_q]     <= ent_d;
        prune_q[wr_ptr_q] <= ent_prune;
        done_q[wr_ptr_q]  <= ent_done;
      end
    end
  end

endmodule

// File: tb/tb_read_d_fetch.sv
// Directed bench for read_d_fetch: lookup fields, full/pop-push, flush, async reset, saturation.
module tb_read_d_fetch;

  logic       clk = 1'b0;
  logic       rst_n, flush, req_valid, req_ready, rom_ce, rsp_valid, rsp_ready;
  logic [7:0] req_i, req_z, rom_addr, rom_d_i, rsp_i, rsp_d;
  logic [1:0] rom_read_i, rsp_sym;
  logic       rsp_prune, rsp_done;
  logic [3:0] cnt_req, cnt_prune;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  read_d_fetch #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_i(req_i), .req_z(req_z),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_d_i(rom_d_i), .rom_read_i(rom_read_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_i(rsp_i), .rsp_sym(rsp_sym),
    .rsp_d(rsp_d), .rsp_prune(rsp_prune), .rsp_done(rsp_done),
    .cnt_req(cnt_req), .cnt_prune(cnt_prune)
  );

  // ROM: address 5 holds {G, 3}; every other address returns sym = addr[1:0], d = addr
  always_comb begin
    rom_read_i = rom_addr[1:0];
    rom_d_i    = rom_addr;
    if (rom_addr == 8'd5) begin
      rom_read_i = 2'b10;
      rom_d_i    = 8'd3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] i, input logic [7:0] z);
    @(negedge clk);
    req_valid = 1'b1;
    req_i     = i;
    req_z     = z;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] i, input logic [1:0] sym,
                            input logic [7:0] d, input logic prune, input logic done);
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_i"},     rsp_i,     i);
    check({tag, "_sym"},   rsp_sym,   sym);
    check({tag, "_d"},     rsp_d,     d);
    check({tag, "_prune"}, rsp_prune, prune);
    check({tag, "_done"},  rsp_done,  done);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_i = '0; req_z = '0;

    // Reset state
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_i = 8'd9;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rom_ce",    rom_ce,    1'b0);
    check("rst_rom_addr",  rom_addr,  8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_i",     rsp_i,     8'h00);
    check("rst_cnt_req",   cnt_req,   4'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Lookup fields, rsp_ready = 1 so every new push replaces the head
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_i = 8'd5; req_z = 8'd2;
    #1;
    check("acc_req_ready", req_ready, 1'b1);
    check("acc_rom_ce",    rom_ce,    1'b1);
    check("acc_rom_addr",  rom_addr,  8'd5);
    @(posedge clk); #1; req_valid = 1'b0;
    check_head("i5z2", 8'd5, 2'b10, 8'd3, 1'b1, 1'b0);
    check("i5z2_cnt_prune", cnt_prune, 4'd1);
    send(8'd5, 8'd3);     check_head("i5z3", 8'd5, 2'b10, 8'd3, 1'b0, 1'b0);
    send(8'hFF, 8'd0);    check_head("m1z0", 8'hFF, 2'b00, 8'd0, 1'b0, 1'b1);
    send(8'hFF, 8'hFF);   check_head("m1zm1", 8'hFF, 2'b00, 8'd0, 1'b1, 1'b0);
    send(8'd5, 8'h80);    check_head("i5zneg", 8'd5, 2'b10, 8'd3, 1'b1, 1'b0);
    send(8'd200, 8'd100); check_head("i200z100", 8'd200, 2'b00, 8'd200, 1'b1, 1'b0);
    send(8'd127, 8'd127); check_head("i127z127", 8'd127, 2'b11, 8'd127, 1'b0, 1'b0);
    check("lk_cnt_req",   cnt_req,   4'd7);
    check("lk_cnt_prune", cnt_prune, 4'd4);
    @(posedge clk); #1;
    check("drain_valid", rsp_valid, 1'b0);
    check("drain_i",     rsp_i,     8'h00);
    check("drain_d",     rsp_d,     8'h00);
    check("empty_rdy",   req_ready, 1'b1);

    // Fill to full with the consumer stalled, across a pointer wrap
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_z = 8'd127;
    for (int k = 0; k < 4; k++) begin
      req_i = 8'(10 + k);
      #1;
      check("fill_ready", req_ready, 1'b1);
      @(posedge clk); #1;
    end
    req_i = 8'd20;
    #1;
    check("full_ready",    req_ready, 1'b0);
    check("full_rom_ce",   rom_ce,    1'b0);
    check("full_rom_addr", rom_addr,  8'h00);
    check("full_head",     rsp_i,     8'd10);
    @(posedge clk); #1;
    check("full_hold_head", rsp_i,  8'd10);
    check("full_hold_cnt",  cnt_req, 4'd11);
    rsp_ready = 1'b1;
    #1;
    check("fullpop_ready",    req_ready, 1'b1);
    check("fullpop_rom_addr", rom_addr,  8'd20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pp_head", rsp_i, 8'd11);
    @(posedge clk); #1; check("pp_head2", rsp_i, 8'd12);
    @(posedge clk); #1; check("pp_head3", rsp_i, 8'd13);
    @(posedge clk); #1; check("pp_head4", rsp_i, 8'd20);
    check("pp_d4", rsp_d, 8'd20);
    @(posedge clk); #1; check("pp_empty", rsp_valid, 1'b0);
    check("fill_cnt_req", cnt_req, 4'd12);

    // Asynchronous reset mid-cycle with two entries buffered
    rsp_ready = 1'b0;
    send(8'd40, 8'd127);
    send(8'd41, 8'd127);
    check("pre_rst_head", rsp_i, 8'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",     rsp_valid, 1'b0);
    check("arst_i",         rsp_i,     8'h00);
    check("arst_cnt_req",   cnt_req,   4'd0);
    check("arst_cnt_prune", cnt_prune, 4'd0);
    check("arst_ready",     req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    send(8'd42, 8'd127);
    check_head("post_rst", 8'd42, 2'b10, 8'd42, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_one", rsp_valid, 1'b0);

    // Flush with three entries buffered
    rsp_ready = 1'b0;
    send(8'd30, 8'd127);
    send(8'd31, 8'd127);
    send(8'd32, 8'd127);
    check("fl_pre_cnt", cnt_req, 4'd4);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_i = 8'd33; rsp_ready = 1'b1;
    #1;
    check("fl_ready",  req_ready, 1'b0);
    check("fl_rom_ce", rom_ce,    1'b0);
    check("fl_valid",  rsp_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check("fl_after_valid", rsp_valid, 1'b0);
    check("fl_cnt_req",     cnt_req,   4'd4);
    check("fl_cnt_prune",   cnt_prune, 4'd0);

    // Saturation: 19 pruned accepts
    req_valid = 1'b1; req_i = 8'hFF; req_z = 8'hFF;
    repeat (11) @(posedge clk);
    #1;
    check("sat_cnt_req_15",   cnt_req,   4'hF);
    check("sat_cnt_prune_11", cnt_prune, 4'd11);
    repeat (8) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("sat_cnt_req",   cnt_req,   4'hF);
    check("sat_cnt_prune", cnt_prune, 4'hF);
    check_head("sat_head", 8'hFF, 2'b00, 8'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
